// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int CNT_W = $clog2(MULDIV_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
// Divide path present only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});

`ifdef MULDIV_DIV_EN
    // Divide: acc = {remainder, dividend bits / quotient bits}; bit 0 is filled by the caller
    logic [WIDTH:0] trial;
    assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};

    always_comb begin
        acc_next = {sum, acc[WIDTH-1:1]};
        q_bit    = 1'b0;
        if (is_div) begin
            q_bit    = ~trial[WIDTH];
            acc_next = {(q_bit ? trial[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], 1'b0};
        end
    end
`else
    always_comb begin
        acc_next = is_div ? acc : {sum, acc[WIDTH-1:1]};
        q_bit    = 1'b0;
    end
`endif

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Define MULDIV_DIV_EN to build the divide datapath; otherwise DIV/DIVU complete as no-ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH == MULDIV_WIDTH) ? CNT_W : $clog2(WIDTH);

    state_e             state;
    op_e                op_r;
    logic               sign_a, sign_b, dz, is_div, q_bit;
    logic [WIDTH-1:0]   a_r, b_r, opnd, mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [CW-1:0]      cnt;

    assign is_div = (op_r == OP_DIV) || (op_r == OP_DIVU);
    assign mag_a  = sign_a ? -a_r : a_r;
    assign mag_b  = sign_b ? -b_r : b_r;
    // Signs are only captured for signed ops, so this negation is MULT-only
    assign prod   = (sign_a ^ sign_b) ? -acc : acc;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (is_div),
        .acc_next (acc_step),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            op_r        <= OP_MULT;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dz          <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            opnd        <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (flush && state != ST_IDLE) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !flush) begin
                            op_r   <= op_e'(op);
                            a_r    <= src_a;
                            b_r    <= src_b;
                            sign_a <= ~op[0] & src_a[WIDTH-1];
                            sign_b <= ~op[0] & src_b[WIDTH-1];
                            dz     <= 1'b0;
                            busy   <= 1'b1;
                            state  <= ST_PREP;
                        end
                    end
                    ST_PREP: begin
                        cnt <= CW'(WIDTH - 1);
                        if (is_div) begin
`ifdef MULDIV_DIV_EN
                            acc   <= {{WIDTH{1'b0}}, mag_a};
                            opnd  <= mag_b;
                            dz    <= (b_r == '0);
                            state <= (b_r == '0) ? ST_FIX : ST_CALC;
`else
                            state <= ST_FIX;
`endif
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, mag_b};
                            opnd  <= mag_a;
                            state <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        acc <= {acc_step[2*WIDTH-1:1], acc_step[0] | q_bit};
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= dz;
                        if (!is_div) begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
`ifdef MULDIV_DIV_EN
                        else if (dz) begin
                            hi <= a_r;
                            lo <= '1;
                        end else begin
                            hi <= sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                            lo <= (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        end
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result of one operation given the HI/LO it starts from
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic edz, output int elat);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        eh  = hi_m;
        el  = lo_m;
        edz = 1'b0;
        elat = 34;
        case (o)
            2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = ua * ub;      eh = p[63:32]; el = p[31:0]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    eh = a; el = '1; edz = 1'b1; elat = 2;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    el = q[31:0]; eh = r[31:0];
                end else begin
                    p = ua / ub; el = p[31:0];
                    p = ua % ub; eh = p[31:0];
                end
`else
                elat = 2;
`endif
            end
        endcase
    endtask

    // Called at a negedge; launches one op and waits for its completion
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        edz;
        int          elat, n;
        model(o, a, b, eh, el, edz, elat);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0; src_a = $urandom; src_b = $urandom;
        check_eq({tag, ".busy"}, 64'(busy), 64'd1);
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!done && n < 60);
        check_eq({tag, ".lat"}, 64'(n), 64'(elat));
        check_eq({tag, ".hi"}, 64'(hi), 64'(eh));
        check_eq({tag, ".lo"}, 64'(lo), 64'(el));
        check_eq({tag, ".dz"}, 64'(div_by_zero), 64'(edz));
        check_eq({tag, ".busy_done"}, 64'(busy), 64'd0);
        hi_m = eh;
        lo_m = el;
    endtask

    // Observe ncyc cycles after a launch; optionally pulse start or flush in one cycle
    task automatic watch(input int ncyc, input int pulse_at, input bit pulse_flush,
                         output int ndone, output int first, output logic [31:0] ghi, output logic [31:0] glo);
        ndone = 0; first = 0; ghi = hi; glo = lo;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) begin first = c; ghi = hi; glo = lo; end
            end
            if (pulse_flush) flush = (c == pulse_at);
            else             start = (c == pulse_at);
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        int          nd, fst;
        logic [31:0] gh, gl, ra, rb;
        logic [1:0]  ro;

        repeat (3) @(negedge clk);
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        check_eq("rst.dz", 64'(div_by_zero), 64'd0);
        check_eq("rst.hi", 64'(hi), 64'd0);
        check_eq("rst.lo", 64'(lo), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult_mixed", OP_MULT, 32'h8000_0000, 32'h8000_0000);

        // Asynchronous reset in the middle of an iteration
        start = 1'b1; op = OP_MULTU; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rstmid.busy", 64'(busy), 64'd0);
        check_eq("rstmid.done", 64'(done), 64'd0);
        check_eq("rstmid.hi", 64'(hi), 64'd0);
        check_eq("rstmid.lo", 64'(lo), 64'd0);
        hi_m = '0; lo_m = '0;
        @(negedge clk);
        reset = 1'b1;
        watch(40, 0, 1'b1, nd, fst, gh, gl);
        check_eq("rstmid.no_done", 64'(nd), 64'd0);

        // Preload HI/LO = 0x1111/0x2222, then flush a launch
        @(negedge clk);
        run_op("preload", OP_MULTU, 32'h0000_3333, 32'h5555_5556);
        check_eq("preload.hi_const", 64'(hi), 64'h1111);
        start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        watch(40, 9, 1'b1, nd, fst, gh, gl);
        check_eq("flush.no_done", 64'(nd), 64'd0);
        check_eq("flush.busy", 64'(busy), 64'd0);
        check_eq("flush.hi", 64'(hi), 64'h1111);
        check_eq("flush.lo", 64'(lo), 64'h2222);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; op = OP_MULTU;
        @(posedge clk); #1;
        check_eq("flush_start.busy", 64'(busy), 64'd0);
        start = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Second start while busy is ignored
        start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        op = OP_MULT; src_a = 32'd7; src_b = 32'd7;
        watch(80, 5, 1'b0, nd, fst, gh, gl);
        check_eq("ign.ndone", 64'(nd), 64'd1);
        check_eq("ign.lat", 64'(fst), 64'd34);
        check_eq("ign.hi", 64'(gh), 64'd0);
        check_eq("ign.lo", 64'(gl), 64'd12);
        hi_m = 32'd0; lo_m = 32'd12;

        // Randomized back-to-back operations
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: ra = $urandom_range(0, 255);
                1: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
